// File: rtl/pipe_seg_reg.sv
// pipe_seg_reg: parametrised inter-stage pipeline register for the RISC-V CPU.
// Carries a data payload and a control payload through DEPTH register stages,
// each with its own valid bit. Supports stall, synchronous flush with selectable
// priority over stall, and a saturating bubble counter for perf/debug.
// A slot that is invalid or flushed always holds all-zero control, so the
// downstream stages never see a write or branch enable from a bubble.
module pipe_seg_reg #(
  parameter int DATA_W           = 64,
  parameter int CTRL_W           = 24,
  parameter int DEPTH            = 1,
  parameter int CLR_DATA         = 0,
  parameter int FLUSH_OVER_STALL = 1,
  parameter int CNT_W            = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              busy,
  output logic [CNT_W-1:0]  bubble_cnt,
  input  logic              cnt_clr
);

  // Only 1..4 stages make sense for a CPU segment register.
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_seg_reg: DEPTH must be in 1..4");
  end

  localparam bit CLR_D = (CLR_DATA != 0);
  localparam bit FOS   = (FLUSH_OVER_STALL != 0);

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]             bubble_cnt_q;

  // Effective flush: with the legacy behaviour a flush seen during a stall is
  // dropped, not remembered; the requester has to hold it until en=1.
  logic fl;
  assign fl = flush & (en | FOS);

  // One bubble per edge, regardless of how many stages the register has.
  logic bubble_ev;
  assign bubble_ev = fl | (en & ~in_valid);

  // Stage registers: flush beats advance, advance beats hold.
  // NOTE: the payload registers get reset too (not just the valid bits), so
  // out_data reads 0 straight out of reset instead of whatever powered up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else if (fl) begin
      valid_q <= '0;
      ctrl_q  <= '0;
      if (CLR_D) data_q <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments make every stage sample the old value
      // of its predecessor, so the loop order below does not matter.
      valid_q[0] <= in_valid;
      ctrl_q[0]  <= in_valid ? in_ctrl : '0;
      data_q[0]  <= (CLR_D && !in_valid) ? '0 : in_data;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        ctrl_q[k]  <= ctrl_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  // Saturating bubble counter; a clear wins over a same-edge increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else if (cnt_clr) begin
      bubble_cnt_q <= '0;
    end else if (bubble_ev && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  // Outputs come straight from registers; no input-to-output path.
  assign out_valid  = valid_q[DEPTH-1];
  assign out_data   = data_q[DEPTH-1];
  assign out_ctrl   = ctrl_q[DEPTH-1];
  assign busy       = |valid_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_seg_reg.sv
// tb_pipe_seg_reg: four parameter variants of pipe_seg_reg share one stimulus
// bus. Instructions issued are pushed into per-instance expected queues; a
// monitor pops and compares whenever an instance advances with out_valid=1.
// Status outputs (hold, flush, counters, reset) are checked directly.
module tb_pipe_seg_reg;

  typedef struct packed {
    logic [63:0] d;
    logic [23:0] c;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic [23:0] in_ctrl;
  logic        cnt_clr;

  // index 0: DEPTH=1, 1: DEPTH=2, 2: DEPTH=2 CLR_DATA=1 FOS=0 CNT_W=4, 3: DEPTH=3
  logic        o_v [4];
  logic [63:0] o_d [4];
  logic [23:0] o_c [4];
  logic        o_b [4];
  logic [15:0] cnt [4];
  logic [3:0]  cnt_c;

  exp_t exp_q [4][$];
  logic adv;
  int   total = 0;
  int   bad   = 0;

  assign cnt[2] = {12'h0, cnt_c};

  pipe_seg_reg #(.DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(o_v[0]), .out_data(o_d[0]),
    .out_ctrl(o_c[0]), .busy(o_b[0]), .bubble_cnt(cnt[0]), .cnt_clr(cnt_clr));

  pipe_seg_reg #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(o_v[1]), .out_data(o_d[1]),
    .out_ctrl(o_c[1]), .busy(o_b[1]), .bubble_cnt(cnt[1]), .cnt_clr(cnt_clr));

  pipe_seg_reg #(.DEPTH(2), .CLR_DATA(1), .FLUSH_OVER_STALL(0), .CNT_W(4)) u_d2c (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(o_v[2]), .out_data(o_d[2]),
    .out_ctrl(o_c[2]), .busy(o_b[2]), .bubble_cnt(cnt_c), .cnt_clr(cnt_clr));

  pipe_seg_reg #(.DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(o_v[3]), .out_data(o_d[3]),
    .out_ctrl(o_c[3]), .busy(o_b[3]), .bubble_cnt(cnt[3]), .cnt_clr(cnt_clr));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus, record issued instructions, and return at the
  // falling edge after the rising edge that consumed it.
  task automatic drive(input logic e, input logic f, input logic v,
                       input logic [63:0] d, input logic [23:0] c);
    en       = e;
    flush    = f;
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
    if (e && v && !f) begin
      exp_q[0].push_back('{d: d, c: c});
      exp_q[1].push_back('{d: d, c: c});
      exp_q[3].push_back('{d: d, c: c});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < 4; i++) exp_q[i].delete();
  endtask

  // Record whether the pipeline moved forward at this edge.
  always @(posedge clk) adv = rst_n && en && !flush;

  // Monitor: pop and compare on every advance that presents a valid output;
  // also check that an invalid output never carries control bits.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (!o_v[i]) check($sformatf("inv%0d_ctrl0", i), {40'h0, o_c[i]}, 64'h0);
      if (i != 2 && adv && o_v[i]) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("unexp%0d", i), {63'h0, o_v[i]}, 64'h0);
        end else begin
          e = exp_q[i].pop_front();
          check($sformatf("sb%0d_data", i), o_d[i], e.d);
          check($sformatf("sb%0d_ctrl", i), {40'h0, o_c[i]}, {40'h0, e.c});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_ctrl = '0; cnt_clr = 1'b0;
    #1;
    // Reset state, before any clock edge.
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst%0d_valid", i), {63'h0, o_v[i]}, 64'h0);
      check($sformatf("rst%0d_data", i), o_d[i], 64'h0);
      check($sformatf("rst%0d_busy", i), {63'h0, o_b[i]}, 64'h0);
      check($sformatf("rst%0d_cnt", i), {48'h0, cnt[i]}, 64'h0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: stream of six tagged instructions.
    for (int n = 0; n < 6; n++) begin
      drive(1'b1, 1'b0, 1'b1, 64'h100 + 64'(n), 24'h5A);
      if (n == 0) begin
        check("t1_d2_valid_first", {63'h0, o_v[1]}, 64'h0);
        check("t1_d2_busy_first", {63'h0, o_b[1]}, 64'h1);
      end
    end
    check("t1_d2_valid", {63'h0, o_v[1]}, 64'h1);
    check("t1_d2_cnt", {48'h0, cnt[1]}, 64'h0);

    // T2: one more instruction, then a 3-cycle stall with changing inputs.
    drive(1'b1, 1'b0, 1'b1, 64'h1FF, 24'hFF);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 64'hBAD0 + 64'(i), 24'h0F);
      check("t2_hold_valid", {63'h0, o_v[0]}, 64'h1);
      check("t2_hold_data", o_d[0], 64'h1FF);
      check("t2_hold_ctrl", {40'h0, o_c[0]}, 64'hFF);
    end
    // Drain with bubbles; the monitor collects the remaining instructions.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 64'h0, 24'h0);
      if (i == 0) begin
        check("t2_d1_bubble_valid", {63'h0, o_v[0]}, 64'h0);
        check("t2_d1_bubble_ctrl", {40'h0, o_c[0]}, 64'h0);
      end
    end
    check("t2_d2_cnt", {48'h0, cnt[1]}, 64'h3);
    check("t2_d2c_cnt", {48'h0, cnt[2]}, 64'h3);

    // T3/T4: fill every instance with 0xDEAD, clear counters, flush under stall.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 64'hDEAD, 24'h33);
    check("t3_d3_full", {63'h0, o_v[3]}, 64'h1);
    cnt_clr = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 64'h0, 24'h0);
    cnt_clr = 1'b0;
    check("t3_cnt_cleared", {48'h0, cnt[1]}, 64'h0);
    drive(1'b0, 1'b1, 1'b0, 64'h0, 24'h0);
    clear_queues();
    check("t3_fos1_valid", {63'h0, o_v[1]}, 64'h0);
    check("t3_fos1_ctrl", {40'h0, o_c[1]}, 64'h0);
    check("t3_fos1_busy", {63'h0, o_b[1]}, 64'h0);
    check("t3_fos1_cnt", {48'h0, cnt[1]}, 64'h1);
    check("t4_clr0_data", o_d[1], 64'hDEAD);
    check("t3_fos0_valid", {63'h0, o_v[2]}, 64'h1);
    check("t3_fos0_ctrl", {40'h0, o_c[2]}, 64'h33);
    check("t3_fos0_data", o_d[2], 64'hDEAD);
    check("t3_fos0_cnt", {48'h0, cnt[2]}, 64'h0);
    // Flush while enabled: the FOS=0, CLR_DATA=1 instance now clears data too.
    drive(1'b1, 1'b1, 1'b0, 64'h0, 24'h0);
    check("t4_clr1_valid", {63'h0, o_v[2]}, 64'h0);
    check("t4_clr1_ctrl", {40'h0, o_c[2]}, 64'h0);
    check("t4_clr1_data", o_d[2], 64'h0);
    check("t4_clr1_busy", {63'h0, o_b[2]}, 64'h0);
    check("t4_clr1_cnt", {48'h0, cnt[2]}, 64'h1);
    check("t4_clr0_data2", o_d[1], 64'hDEAD);
    check("t4_fos1_cnt2", {48'h0, cnt[1]}, 64'h2);

    // T5: 20 bubble edges saturate the 4-bit counter at 15.
    cnt_clr = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 64'h0, 24'h0);
    cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 64'h0, 24'h0);
      check("t5_sat_cnt", {48'h0, cnt[2]}, (i < 15) ? 64'(i + 1) : 64'd15);
    end
    check("t5_wide_cnt", {48'h0, cnt[1]}, 64'd20);
    cnt_clr = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 64'h0, 24'h0);
    cnt_clr = 1'b0;
    check("t5_clr_wins_c", {48'h0, cnt[2]}, 64'h0);
    check("t5_clr_wins_w", {48'h0, cnt[1]}, 64'h0);

    // T6: one bubble, fill DEPTH=3, then asynchronous reset between edges.
    drive(1'b1, 1'b0, 1'b0, 64'h0, 24'h0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 64'hC0DE + 64'(i), 24'h77);
    check("t6_pre_busy", {63'h0, o_b[3]}, 64'h1);
    check("t6_pre_cnt", {48'h0, cnt[3]}, 64'h1);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    clear_queues();
    check("t6_rst_valid", {63'h0, o_v[3]}, 64'h0);
    check("t6_rst_ctrl", {40'h0, o_c[3]}, 64'h0);
    check("t6_rst_data", o_d[3], 64'h0);
    check("t6_rst_busy", {63'h0, o_b[3]}, 64'h0);
    check("t6_rst_cnt", {48'h0, cnt[3]}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal operation resumes after reset release.
    drive(1'b1, 1'b0, 1'b1, 64'h42, 24'h11);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 64'h0, 24'h0);
    check("post_rst_cnt", {48'h0, cnt[3]}, 64'h3);
    check("post_rst_q0", 64'(exp_q[0].size()), 64'h0);
    check("post_rst_q1", 64'(exp_q[1].size()), 64'h0);
    check("post_rst_q3", 64'(exp_q[3].size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
